alu_cmd_issue: RTL

//  Upstream feeder for the registered 4-bit add/sub ALU stage. Accepts {op,a,b} commands on a

---
 rtl/alu_cmd_pkg.sv | 21 ++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_cmd_issue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_cmd_pkg.sv
// Shared types and constants for the ALU command issue block.
//   OP_ADD / OP_SUB : opcode encodings
//   OPND_W / RES_W  : operand and result widths
//   alu_cmd_t       : one queued command {op, a, b}
//   state_t         : issue FSM states
package alu_cmd_pkg;

  localparam logic        OP_ADD = 1'b0;
  localparam logic        OP_SUB = 1'b1;
  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = 5;

  typedef struct packed {
    logic              op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO with async active-low reset.
//   clk, reset_n    : clock, asynchronous active-low reset
//   push, wdata     : write strobe and data (ignored when full)
//   pop, rdata      : read strobe (ignored when empty) and head data
//   full, empty     : occupancy flags
//   count           : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/alu_cmd_issue.sv
// Feeds a registered 4-bit add/sub ALU from a command FIFO and returns results in order.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          : command handshake; cmd_op/cmd_a/cmd_b payload
//   alu_op/alu_a/alu_b           : operands to the ALU (held when nothing issues)
//   alu_result                   : registered ALU result, valid the cycle after issue
//   rsp_valid/rsp_ready          : response handshake; rsp_result payload
//   stat_issued/stat_borrow      : saturating counters, only with ALU_CMD_STATS_EN defined
module alu_cmd_issue
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  output logic              alu_op,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result
`ifdef ALU_CMD_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_borrow
`endif
);

  localparam int unsigned RSP_DEPTH = 2;
  localparam int unsigned CW        = $clog2(DEPTH + 1);

  alu_cmd_t        cmd_in, head, alu_q;
  logic            push, issue, rsp_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, fifo_cnt_next;
  logic            cmd_ready_q, inflight_q;
  logic [2:0]      credit_used;
  state_t          state_q, state_d;

  logic [RES_W-1:0] rsp_mem_q [RSP_DEPTH];
  logic             rsp_wr_q, rsp_rd_q;
  logic [1:0]       rsp_count_q;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = cmd_ready_q;
  assign push      = cmd_valid && cmd_ready_q;
  assign rsp_valid = (rsp_count_q != 2'd0);
  assign rsp_pop   = rsp_valid && rsp_ready;

  // Credit covers buffered results plus the one in the ALU; a same-cycle pop frees a slot.
  assign credit_used = 3'(rsp_count_q) + 3'(inflight_q) - 3'(rsp_pop);
  assign issue       = !fifo_empty && (credit_used < 3'(RSP_DEPTH));

  alu_cmd_fifo #(
    .WIDTH($bits(alu_cmd_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .wdata  (cmd_in),
    .pop    (issue),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // cmd_ready is registered, so it is computed from the next-cycle FIFO occupancy.
  assign fifo_cnt_next = fifo_count + CW'(push) - CW'(issue);

  assign alu_op = issue ? head.op : alu_q.op;
  assign alu_a  = issue ? head.a  : alu_q.a;
  assign alu_b  = issue ? head.b  : alu_q.b;

  assign rsp_result = rsp_valid ? rsp_mem_q[rsp_rd_q] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready_q <= 1'b0;
      inflight_q  <= 1'b0;
      alu_q       <= '0;
      state_q     <= IDLE;
      rsp_mem_q   <= '{default: '0};
      rsp_wr_q    <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_count_q <= 2'd0;
    end else begin
      cmd_ready_q <= (fifo_cnt_next != CW'(DEPTH));
      inflight_q  <= issue;
      state_q     <= state_d;
      if (issue) alu_q <= head;
      if (inflight_q) begin
        rsp_mem_q[rsp_wr_q] <= alu_result;
        rsp_wr_q            <= ~rsp_wr_q;
      end
      if (rsp_pop) rsp_rd_q <= ~rsp_rd_q;
      rsp_count_q <= rsp_count_q + 2'(inflight_q) - 2'(rsp_pop);
    end
  end

  // Status FSM: tracks whether the issue path is idle, streaming or waiting on credit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = RUN;
      RUN: begin
        if (fifo_empty)  state_d = IDLE;
        else if (!issue) state_d = STALL;
      end
      STALL:   if (rsp_pop) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_issued_q, stat_borrow_q;
  logic        borrow_tag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued_q <= '0;
      stat_borrow_q <= '0;
      borrow_tag_q  <= 1'b0;
    end else begin
      // Tag travels with inflight so the borrow is counted when the result is captured.
      borrow_tag_q <= issue && (head.op == OP_SUB) && (head.a < head.b);
      if (issue && stat_issued_q != 16'hFFFF) stat_issued_q <= stat_issued_q + 16'd1;
      if (inflight_q && borrow_tag_q && stat_borrow_q != 16'hFFFF) begin
        stat_borrow_q <= stat_borrow_q + 16'd1;
      end
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_borrow = stat_borrow_q;
`endif

endmodule
